// File: rtl/mbist_pkg.sv
// Shared MBIST definitions: analyzer/controller state encoding and the
// largest supported BRAM read latency.
package mbist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mbist_state_e;

    // Largest BRAM read latency the analyzer delay line is built for
    localparam int RD_LAT_MAX  = 4;
    // Width of the drain counter, which counts 0 .. RD_LAT-1
    localparam int DRAIN_CNT_W = $clog2(RD_LAT_MAX);

endpackage

// File: rtl/mbist_ra_pipe.sv
// Delay line for {chk, addr, exp} beats.
// Matches the BRAM read latency, so each beat meets its read data at the output.
// Only the valid (chk) bit is reset; the payload is don't-care while chk=0.
module mbist_ra_pipe
    import mbist_pkg::*;
#(
    parameter int STAGES = 1,
    parameter int W      = 1
) (
    input  logic         bist_clk,
    input  logic         rst_h,
    input  logic         in_vld,
    input  logic [W-1:0] in_data,
    output logic         out_vld,
    output logic [W-1:0] out_data
);

    logic         vld_q  [STAGES];
    logic         vld_d  [STAGES];
    logic [W-1:0] data_q [STAGES];
    logic [W-1:0] data_d [STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                // First stage takes the freshly captured beat
                always_comb begin
                    vld_d[gi]  = in_vld;
                    data_d[gi] = in_data;
                end
            end else begin : g_tail
                // Later stages shift the previous stage forward
                always_comb begin
                    vld_d[gi]  = vld_q[gi-1];
                    data_d[gi] = data_q[gi-1];
                end
            end

            // Stage register; only the valid bit needs a reset value
            always_ff @(posedge bist_clk) begin
                if (rst_h) begin
                    vld_q[gi] <= 1'b0;
                end else begin
                    vld_q[gi] <= vld_d[gi];
                end
                data_q[gi] <= data_d[gi];
            end
        end
    endgenerate

    assign out_vld  = vld_q[STAGES-1];
    assign out_data = data_q[STAGES-1];

endmodule

// File: rtl/mbist_response_analyzer.sv
// Per-UUT MBIST response analyzer.
// It captures the expected data and address of each check beat and delays them by the
// BRAM read latency. It then compares them with port-A read data and reports sticky
// fail / done to the controller.
// Optional fail log: define MBIST_RA_DIAG_EN.
module mbist_response_analyzer
    import mbist_pkg::*;
#(
    parameter int ADDRA_W   = 8,
    parameter int DA_W      = 35,
    parameter int RD_LAT    = 1,
    parameter int CNT_W     = 8,
    parameter int LOG_DEPTH = 4
) (
    input  logic             bist_clk,
    input  logic             rst_h,
    input  logic             uut_en,
    input  logic             tst_capture,
    input  logic             tst_check_ce,
    input  logic [ADDRA_W:0] tst_ADDRA,
    input  logic [DA_W:0]    tst_DIA,
    input  logic [DA_W:0]    bram_DOA,
    input  logic             alg_end,
    output logic             inter_fail,
    output logic             inter_done,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [ADDRA_W:0] first_addr,
    input  logic             diag_rd,
    output logic             diag_valid,
    output logic [ADDRA_W:0] diag_addr,
    output logic [DA_W:0]    diag_syn
);

    localparam int PW = (ADDRA_W + 1) + (DA_W + 1);

    mbist_state_e           state_q, state_d;
    logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic                   inter_fail_q, inter_fail_d;
    logic [CNT_W-1:0]       fail_cnt_q, fail_cnt_d;
    logic [ADDRA_W:0]       first_addr_q, first_addr_d;

    logic                   p_chk;
    logic [ADDRA_W:0]       p_addr;
    logic [DA_W:0]          p_exp;
    logic                   mismatch;

    // Beats offered while uut_en is low never enter the pipe as checks
    mbist_ra_pipe #(.STAGES(RD_LAT), .W(PW)) u_pipe (
        .bist_clk (bist_clk),
        .rst_h    (rst_h),
        .in_vld   (tst_capture & uut_en & tst_check_ce),
        .in_data  ({tst_ADDRA, tst_DIA}),
        .out_vld  (p_chk),
        .out_data ({p_addr, p_exp})
    );

    assign mismatch = p_chk && (bram_DOA != p_exp);

    // Run-phase FSM. Captures in the alg_end cycle are still checked:
    // DRAIN waits RD_LAT cycles for them to leave the pipe.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            IDLE: begin
                if (uut_en) state_d = RUN;
            end
            RUN: begin
                if (alg_end) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_CNT_W'(RD_LAT - 1)) begin
                    state_d = DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_CNT_W'(1);
                end
            end
            DONE: begin
                state_d = DONE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge bist_clk) begin
        if (rst_h) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Mismatch bookkeeping: sticky flag, saturating count, first failing address
    always_comb begin
        inter_fail_d = inter_fail_q;
        fail_cnt_d   = fail_cnt_q;
        first_addr_d = first_addr_q;
        if (mismatch) begin
            inter_fail_d = 1'b1;
            if (fail_cnt_q == '0) first_addr_d = p_addr;
            if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
        end
    end

    // Result registers
    always_ff @(posedge bist_clk) begin
        if (rst_h) begin
            inter_fail_q <= 1'b0;
            fail_cnt_q   <= '0;
            first_addr_q <= '0;
        end else begin
            inter_fail_q <= inter_fail_d;
            fail_cnt_q   <= fail_cnt_d;
            first_addr_q <= first_addr_d;
        end
    end

    assign inter_fail = inter_fail_q;
    assign inter_done = (state_q == DONE);
    assign fail_cnt   = fail_cnt_q;
    assign first_addr = first_addr_q;

`ifdef MBIST_RA_DIAG_EN
    localparam int LP_W = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;

    logic [ADDRA_W:0] log_addr_mem [LOG_DEPTH];
    logic [DA_W:0]    log_syn_mem  [LOG_DEPTH];
    logic [LP_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LP_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LP_W:0]    log_cnt_q, log_cnt_d;
    logic             log_push, log_pop;

    // Fullness is judged before this cycle's pop, so a full log drops the new entry
    always_comb begin
        log_push  = mismatch && (log_cnt_q != (LP_W+1)'(LOG_DEPTH));
        log_pop   = diag_rd && (log_cnt_q != '0);
        wr_ptr_d  = log_push ? wr_ptr_q + LP_W'(1) : wr_ptr_q;
        rd_ptr_d  = log_pop  ? rd_ptr_q + LP_W'(1) : rd_ptr_q;
        log_cnt_d = log_cnt_q;
        if (log_push && !log_pop) log_cnt_d = log_cnt_q + (LP_W+1)'(1);
        if (!log_push && log_pop) log_cnt_d = log_cnt_q - (LP_W+1)'(1);
    end

    // Log storage; contents are only visible through a valid head
    always_ff @(posedge bist_clk) begin
        if (log_push) begin
            log_addr_mem[wr_ptr_q] <= p_addr;
            log_syn_mem[wr_ptr_q]  <= p_exp ^ bram_DOA;
        end
    end

    // Log pointers and occupancy
    always_ff @(posedge bist_clk) begin
        if (rst_h) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            log_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            log_cnt_q <= log_cnt_d;
        end
    end

    assign diag_valid = (log_cnt_q != '0);
    assign diag_addr  = diag_valid ? log_addr_mem[rd_ptr_q] : '0;
    assign diag_syn   = diag_valid ? log_syn_mem[rd_ptr_q]  : '0;
`else
    localparam int lp_unused_log_depth = LOG_DEPTH;
    logic unused_diag_rd;
    assign unused_diag_rd = diag_rd;
    assign diag_valid     = 1'b0;
    assign diag_addr      = '0;
    assign diag_syn       = '0;
`endif

endmodule
